// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner select for the shared data bus with one-cycle turnaround.
// Define BUS_ARB_TIMEOUT_EN to force release after MAX_HOLD cycles of ownership.
module bus_arbiter #(
    parameter int NREQ = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDXW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] data_en,
    output logic [IDXW-1:0] owner,
    output logic            bus_busy,
    output logic            preempt
);
    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
    state_t state, state_n;
    logic [IDXW-1:0] last, own, win;
    logic [IDXW:0] idx;
    logic [NREQ-1:0] en_r;
    logic found, take, expire, busy_r, pre_r, pre_n;
    always_comb begin
        win = '0;
        found = 1'b0;
        idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (IDXW+1)'(last) + (IDXW+1)'(i);
            idx = idx >= (IDXW+1)'(NREQ) ? idx - (IDXW+1)'(NREQ) : idx;
            if (!found && req[idx[IDXW-1:0]]) begin
                win = idx[IDXW-1:0];
                found = 1'b1;
            end
        end
    end
`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] hold;
    assign expire = hold == 8'(MAX_HOLD - 1);
    always_ff @(posedge clk) begin
        if (rst)
            hold <= '0;
        else if (take)
            hold <= '0;
        else if (state == GRANT)
            hold <= hold + 8'd1;
    end
`else
    assign expire = MAX_HOLD == 0;
`endif
    always_comb begin
        state_n = state;
        pre_n = 1'b0;
        case (state)
            IDLE:  state_n = found ? GRANT : IDLE;
            GRANT: begin
                state_n = (!req[own] || expire) ? TURN : GRANT;
                pre_n = req[own] && expire;
            end
            TURN:  state_n = found ? GRANT : IDLE;
            default: state_n = IDLE;
        endcase
    end
    assign take = state != GRANT && state_n == GRANT;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            en_r <= '0;
            own <= '0;
            busy_r <= 1'b0;
            pre_r <= 1'b0;
            last <= IDXW'(NREQ - 1);
        end else begin
            state <= state_n;
            busy_r <= state_n == GRANT;
            pre_r <= pre_n;
            en_r <= state_n != GRANT ? '0 : take ? NREQ'(1) << win : en_r;
            if (take) begin
                own <= win;
                last <= win;
            end
        end
    end
    assign data_en = en_r;
    assign owner = busy_r ? own : '0;
    assign bus_busy = busy_r;
    assign preempt = pre_r;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: randomized and directed stimulus against a bus-ownership reference model with a scoreboard.
module tb_bus_arbiter;
    localparam int N = 4;
    localparam int MH = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] data_en;
    logic [1:0] owner;
    logic bus_busy, preempt;
    typedef struct {int en; int own; int busy; int pre;} exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cur = -1;
    int last = N - 1;
    int held = 0;
    int pre_m = 0;

    bus_arbiter #(.NREQ(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req), .data_en(data_en),
        .owner(owner), .bus_busy(bus_busy), .preempt(preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Bus is either free (arbitrate this edge) or owned; a release edge never grants.
    task automatic model_step();
        exp_t e;
        pre_m = 0;
        if (rst) begin
            cur = -1;
            last = N - 1;
            held = 0;
        end else if (cur >= 0) begin
            if (!req[cur])
                cur = -1;
`ifdef BUS_ARB_TIMEOUT_EN
            else if (held == MH) begin
                cur = -1;
                pre_m = 1;
            end
`endif
            else
                held++;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last + k) % N;
                if (req[c]) begin
                    cur = c;
                    last = c;
                    held = 1;
                    break;
                end
            end
        end
        e.en = cur >= 0 ? (1 << cur) : 0;
        e.own = cur >= 0 ? cur : 0;
        e.busy = cur >= 0 ? 1 : 0;
        e.pre = pre_m;
        q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic [N-1:0] rv);
        rst = r;
        req = rv;
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("data_en", int'(data_en), e.en);
            chk("owner", int'(owner), e.own);
            chk("bus_busy", int'(bus_busy), e.busy);
            chk("preempt", int'(preempt), e.pre);
            chk("onehot", int'($onehot0(data_en)), 1);
        end
    end

    initial begin
        repeat (2) cyc(1'b1, 4'b1111);
        repeat (3) cyc(1'b0, 4'b1111);
        repeat (3) cyc(1'b0, 4'b0000);
        repeat (3) cyc(1'b0, 4'b0100);
        repeat (3) cyc(1'b0, 4'b0000);
        repeat (4) begin
            for (int b = 0; b < 8 && cur < 0; b++) cyc(1'b0, 4'b1011);
            cyc(1'b0, 4'b1011);
            cyc(1'b0, 4'b1011 & ~(4'b0001 << cur));
        end
        repeat (2) cyc(1'b0, 4'b0000);
        repeat (2) cyc(1'b0, 4'b0010);
        repeat (2) cyc(1'b0, 4'b0110);
        repeat (3) cyc(1'b0, 4'b0100);
        repeat (2) cyc(1'b0, 4'b0000);
        repeat (40) cyc(1'b0, 4'b0011);
        repeat (2) cyc(1'b0, 4'b0000);
        repeat (2) cyc(1'b0, 4'b0100);
        cyc(1'b1, 4'b0100);
        repeat (4) cyc(1'b0, 4'b0101);
        repeat (2) cyc(1'b0, 4'b0000);
        repeat (600) begin
            logic [N-1:0] rv;
            logic r;
            rv = N'($urandom);
            r = $urandom_range(0, 49) == 0;
            cyc(r, rv);
            repeat ($urandom_range(0, 5)) cyc(1'b0, rv);
        end
        repeat (2) cyc(1'b0, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
